// File: rtl/q_table_updater.sv
// q_table_updater
//   Owns the Q-table (N_STATES rows of four signed Q8.8 entries). Two jobs:
//   - Serves one packed Q row per cycle to the policy generator.
//   - Applies one Q-learning update per accepted start pulse:
//       Q(s,a) += alpha * (r + gamma * max Q(s',*) - Q(s,a))
//     The update runs through IDLE->FETCH->TARGET->DELTA->WRITE->DONE.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset (clears the table too)
//   rd_state        row to present on rd_q_values (1-cycle latency)
//   rd_q_values     {a3,a2,a1,a0}, 16-bit signed Q8.8 each; 0 when rd_state is out of range
//   start           update request, honoured only in IDLE
//   state/action/next_state/terminal/reward/alpha/gamma
//                   transition fields, sampled together with start
//   busy            high outside IDLE
//   done            one-cycle pulse after the table write
//   error           one-cycle pulse when a request is rejected
//
// Build option
//   Q_SATURATE_EN   when defined, target/delta/new Q saturate to 16-bit signed
//                   limits; otherwise they wrap to their low 16 bits.
module q_table_updater #(
  parameter int N_STATES = 16,
  parameter int SW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] rd_state,
  output logic [63:0]   rd_q_values,
  input  logic          start,
  input  logic [SW-1:0] state,
  input  logic [3:0]    action,
  input  logic [SW-1:0] next_state,
  input  logic          terminal,
  input  logic [15:0]   reward,
  input  logic [15:0]   alpha,
  input  logic [15:0]   gamma,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TARGET, S_DELTA, S_WRITE, S_DONE
  } fsm_t;

  fsm_t                st_q;
  logic                busy_q, done_q, error_q;
  logic [63:0]         rd_q;
  logic [3:0][15:0]    tbl_q [N_STATES];

  logic [SW-1:0]       s_q, sn_q;
  logic [1:0]          a_q;
  logic                term_q;
  logic signed [15:0]  reward_q;
  logic [15:0]         alpha_q, gamma_q;
  logic signed [15:0]  q_sa_q, maxq_q, target_q, delta_q;

  logic signed [15:0]  q_sa_d, maxq_d, target_d, delta_d, newq_d;
  logic signed [31:0]  g_prod, a_prod;
  logic                req_ok;

  // Reduce a 32-bit intermediate to a 16-bit Q8.8 result.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
`ifdef Q_SATURATE_EN
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  function automatic logic signed [15:0] row_max(input logic [3:0][15:0] r);
    logic signed [15:0] m;
    m = $signed(r[0]);
    for (int i = 1; i < 4; i++)
      if ($signed(r[i]) > m) m = $signed(r[i]);
    return m;
  endfunction

  function automatic logic [1:0] act_idx(input logic [3:0] a);
    case (a)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic in_range(input logic [SW-1:0] s);
    return int'(s) < N_STATES;
  endfunction

  assign req_ok = $onehot(action) && in_range(state) && in_range(next_state);

  // FETCH: both reads come from the pre-update table, so a self-loop sees old values.
  assign q_sa_d = $signed(tbl_q[s_q][a_q]);
  assign maxq_d = term_q ? 16'sd0 : row_max(tbl_q[sn_q]);

  // TARGET: alpha/gamma are unsigned, so zero-extend before the signed multiply.
  assign g_prod   = $signed({16'd0, gamma_q}) * 32'(maxq_q);
  assign target_d = sat16(32'(reward_q) + (g_prod >>> 8));

  // DELTA
  assign delta_d  = sat16(32'(target_q) - 32'(q_sa_q));

  // WRITE
  assign a_prod   = $signed({16'd0, alpha_q}) * 32'(delta_q);
  assign newq_d   = sat16(32'(q_sa_q) + (a_prod >>> 8));

  // Control, table and read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < N_STATES; i++) tbl_q[i] <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      // Non-blocking read gives read-before-write on the WRITE edge.
      rd_q    <= in_range(rd_state) ? tbl_q[rd_state] : '0;
      case (st_q)
        S_IDLE: begin
          if (start) begin
            if (req_ok) begin
              st_q   <= S_FETCH;
              busy_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_FETCH:  st_q <= S_TARGET;
        S_TARGET: st_q <= S_DELTA;
        S_DELTA:  st_q <= S_WRITE;
        S_WRITE: begin
          tbl_q[s_q][a_q] <= newq_d;
          st_q            <= S_DONE;
          done_q          <= 1'b1;
        end
        S_DONE: begin
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: no reset, only meaningful while busy.
  always_ff @(posedge clk) begin
    if (st_q == S_IDLE && start) begin
      s_q      <= state;
      sn_q     <= next_state;
      a_q      <= act_idx(action);
      term_q   <= terminal;
      reward_q <= $signed(reward);
      alpha_q  <= alpha;
      gamma_q  <= gamma;
    end
    if (st_q == S_FETCH) begin
      q_sa_q <= q_sa_d;
      maxq_q <= maxq_d;
    end
    if (st_q == S_TARGET) target_q <= target_d;
    if (st_q == S_DELTA)  delta_q  <= delta_d;
  end

  assign rd_q_values = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_q_table_updater.sv
// Directed bench for q_table_updater: a vector table of transactions with
// hand-computed row contents, plus hand-written sequences for start-while-busy,
// read-before-write and reset in the middle of an update.
module tb_q_table_updater;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rd_state = '0;
  logic [63:0] rd_q_values;
  logic        start = 1'b0;
  logic [3:0]  state = '0, action = '0, next_state = '0;
  logic        terminal = 1'b0;
  logic [15:0] reward = '0, alpha = '0, gamma = '0;
  logic        busy, done, error;

  int n_chk = 0;
  int n_bad = 0;

  q_table_updater #(.N_STATES(16), .SW(4)) dut (
    .clk(clk), .rst(rst), .rd_state(rd_state), .rd_q_values(rd_q_values),
    .start(start), .state(state), .action(action), .next_state(next_state),
    .terminal(terminal), .reward(reward), .alpha(alpha), .gamma(gamma),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  s;
    logic [3:0]  a;
    logic [3:0]  sn;
    logic        term;
    logic [15:0] r;
    logic [15:0] al;
    logic [15:0] g;
    logic        err;
    logic [63:0] row;  // expected row s afterwards
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] s, input logic [3:0] a,
                               input logic [3:0] sn, input logic term,
                               input logic [15:0] r, input logic [15:0] al,
                               input logic [15:0] g, input logic err,
                               input logic [63:0] row);
    vec_t v;
    v.s = s; v.a = a; v.sn = sn; v.term = term; v.r = r;
    v.al = al; v.g = g; v.err = err; v.row = row;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction from IDLE, check handshake timing, then read row v.s.
  task automatic run_update(input vec_t v, input string tag);
    int done_at;
    state = v.s; action = v.a; next_state = v.sn; terminal = v.term;
    reward = v.r; alpha = v.al; gamma = v.g; start = 1'b1;
    tick();  // accept edge
    start = 1'b0;
    // Scramble inputs after acceptance; the update must not see them.
    state = 4'hF; next_state = 4'hF; action = 4'b0100; terminal = ~v.term;
    reward = 16'h1234; alpha = 16'hFFFF; gamma = 16'hFFFF;
    if (v.err) begin
      check({tag, " error pulse"}, 64'(error), 64'd1);
      check({tag, " busy on reject"}, 64'(busy), 64'd0);
      tick();
      check({tag, " error width"}, 64'(error), 64'd0);
      check({tag, " no done"}, 64'(done), 64'd0);
    end else begin
      check({tag, " busy after accept"}, 64'(busy), 64'd1);
      done_at = 0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (done && done_at == 0) done_at = k;
      end
      check({tag, " done edge"}, 64'(done_at), 64'd4);
      tick();
      check({tag, " done cleared"}, 64'(done), 64'd0);
      check({tag, " busy cleared"}, 64'(busy), 64'd0);
    end
    rd_state = v.s;
    tick();
    check({tag, " row"}, rd_q_values, v.row);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int extra_done;

    vecs[0] = mkv(4'd0, 4'b0001, 4'd1, 1'b0, 16'h0100, 16'h0080, 16'h0080, 1'b0, 64'h0000_0000_0000_0080);
    vecs[1] = mkv(4'd0, 4'b0001, 4'd0, 1'b0, 16'h0100, 16'h0080, 16'h0080, 1'b0, 64'h0000_0000_0000_00E0);
    vecs[2] = mkv(4'd0, 4'b0011, 4'd1, 1'b0, 16'h0100, 16'h0080, 16'h0080, 1'b1, 64'h0000_0000_0000_00E0);
    vecs[3] = mkv(4'd2, 4'b1000, 4'd0, 1'b1, 16'h7F00, 16'h0100, 16'h0000, 1'b0, 64'h7F00_0000_0000_0000);
`ifdef Q_SATURATE_EN
    vecs[4] = mkv(4'd2, 4'b1000, 4'd2, 1'b0, 16'h7F00, 16'h0100, 16'h0100, 1'b0, 64'h7FFF_0000_0000_0000);
    vecs[5] = mkv(4'd3, 4'b0100, 4'd2, 1'b0, 16'hFF00, 16'h0100, 16'h0080, 1'b0, 64'h0000_3EFF_0000_0000);
`else
    vecs[4] = mkv(4'd2, 4'b1000, 4'd2, 1'b0, 16'h7F00, 16'h0100, 16'h0100, 1'b0, 64'hFE00_0000_0000_0000);
    vecs[5] = mkv(4'd3, 4'b0100, 4'd2, 1'b0, 16'hFF00, 16'h0100, 16'h0080, 1'b0, 64'h0000_FF00_0000_0000);
`endif
    // -1/256 target with alpha 0.5: floor shift gives -1, not 0.
    vecs[6] = mkv(4'd4, 4'b0010, 4'd3, 1'b1, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 64'h0000_0000_FFFF_0000);
    vecs[7] = mkv(4'd4, 4'b0000, 4'd3, 1'b0, 16'h0100, 16'h0100, 16'h0100, 1'b1, 64'h0000_0000_FFFF_0000);

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("reset rd_q_values", rd_q_values, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset error", 64'(error), 64'd0);
    tick(); tick();
    #2 rst = 1'b0;
    rd_state = 4'd0;
    tick();
    check("post-reset row0", rd_q_values, 64'd0);

    for (int i = 0; i < 8; i++) run_update(vecs[i], $sformatf("vec%0d", i));

    // Start while busy is ignored; read-before-write on the write edge.
    rd_state = 4'd5;
    state = 4'd5; action = 4'b0001; next_state = 4'd5; terminal = 1'b1;
    reward = 16'h0200; alpha = 16'h0100; gamma = 16'h0000; start = 1'b1;
    tick();                 // accept
    start = 1'b0;
    done_at = 0;
    tick();                 // edge 1
    state = 4'd6; action = 4'b0001; next_state = 4'd6; start = 1'b1;
    tick();                 // edge 2, start must be ignored
    start = 1'b0;
    tick();                 // edge 3
    check("busy2 no early done", 64'(done), 64'd0);
    tick();                 // edge 4, write edge
    check("busy2 done at 4", 64'(done), 64'd1);
    check("rbw old row", rd_q_values, 64'd0);
    tick();
    check("rbw new row", rd_q_values, 64'h0000_0000_0000_0200);
    check("busy2 idle", 64'(busy), 64'd0);
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done || busy) extra_done++;
    end
    check("ignored start no second run", 64'(extra_done), 64'd0);
    rd_state = 4'd6;
    tick();
    check("row6 untouched", rd_q_values, 64'd0);

    // Reset asserted while in DELTA.
    state = 4'd7; action = 4'b0001; next_state = 4'd0; terminal = 1'b1;
    reward = 16'h0100; alpha = 16'h0100; gamma = 16'h0000; start = 1'b1;
    tick();                 // accept -> FETCH
    start = 1'b0;
    tick();                 // -> TARGET
    tick();                 // -> DELTA
    check("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid-reset busy", 64'(busy), 64'd0);
    check("mid-reset rd_q_values", rd_q_values, 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_state = 4'(i);
      tick();
      check($sformatf("cleared row%0d", i), rd_q_values, 64'd0);
    end
    run_update(mkv(4'd7, 4'b0001, 4'd0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b0,
                   64'h0000_0000_0000_0100), "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
